// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR coefficient loader.
// Optional feature macro used by the loader files: FIR_COEFF_CLEAR_EN.
package fir_pkg;

  // Default geometry; matches the fir_block defaults.
  localparam int FIR_WIDTH_DEF = 16;
  localparam int FIR_TAPS_DEF  = 8;

  // Loader states:
  //   ST_IDLE  : waiting for the first beat of a load
  //   ST_LOAD  : assembling beats into the shadow bank
  //   ST_DRAIN : over-long load, discarding beats up to cfg_last
  //   ST_PEND  : shadow complete, waiting for a sample boundary
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_PEND  = 2'd3
  } fir_state_e;

  // Lowest bit of tap k inside a flat TAPS*WIDTH bus.
  function automatic int unsigned tap_lo(input int unsigned tap, input int unsigned width);
    return tap * width;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient storage for the FIR chain.
// The shadow bank is written one tap at a time; a commit copies the whole
// shadow bank into the active bank in a single edge so the taps never see
// a partial update.
// Under FIR_COEFF_CLEAR_EN an extra clear input zeroes the shadow bank.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH_DEF,
  parameter int TAPS  = FIR_TAPS_DEF,
  parameter int IDXW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [IDXW-1:0]       i_wr_idx,
  input  logic [WIDTH-1:0]      i_wr_data,
`ifdef FIR_COEFF_CLEAR_EN
  input  logic                  i_clear,
`endif
  input  logic                  i_commit,
  output logic [TAPS*WIDTH-1:0] o_active
);

  logic [WIDTH-1:0] r_shadow [TAPS];
  logic [WIDTH-1:0] r_active [TAPS];

  // Shadow bank: single-tap writes from the loader, optional bulk clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
`ifdef FIR_COEFF_CLEAR_EN
      if (i_clear) begin
        for (int k = 0; k < TAPS; k++) begin
          r_shadow[k] <= '0;
        end
      end else
`endif
      if (i_wr_en) begin
        r_shadow[i_wr_idx] <= i_wr_data;
      end
    end
  end

  // Active bank: atomic copy of the whole shadow bank on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        r_active[k] <= '0;
      end
    end else if (i_commit) begin
      for (int k = 0; k < TAPS; k++) begin
        r_active[k] <= r_shadow[k];
      end
    end
  end

  // Flatten the active bank; tap k sits at [k*WIDTH +: WIDTH].
  for (genvar g = 0; g < TAPS; g++) begin : g_flat
    assign o_active[tap_lo(g, WIDTH) +: WIDTH] = r_active[g];
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the transposed FIR chain.
// Serial beats (valid/ready) fill a shadow bank; the bank is committed to the
// taps only at a sample_strobe, so the filter never mixes old and new sets.
// Malformed loads (too short or too long) pulse load_err and never reach
// the active bank.
// Optional feature: FIR_COEFF_CLEAR_EN adds cfg_clear, which zeroes the
// shadow bank from IDLE and arms a commit of an all-zero (muted) bank.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | ready for the first beat; index at 0
//   ST_LOAD  | beats 1..TAPS-1 land in shadow[idx]
//   ST_DRAIN | load overran TAPS beats; swallow beats through cfg_last
//   ST_PEND  | shadow complete; cfg_ready low until sample_strobe commits
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH_DEF,
  parameter int TAPS  = FIR_TAPS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  input  logic [WIDTH-1:0]      cfg_data,
  input  logic                  cfg_last,
  output logic                  cfg_ready,
`ifdef FIR_COEFF_CLEAR_EN
  input  logic                  cfg_clear,
`endif
  input  logic                  sample_strobe,
  output logic [TAPS*WIDTH-1:0] coeff_out,
  output logic                  busy,
  output logic                  commit_done,
  output logic                  load_err
);

  localparam int             IDXW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TAPS - 1);

  fir_state_e        r_state;
  logic [IDXW-1:0]   r_idx;
  logic              r_commit_done;
  logic              r_load_err;

  logic              w_beat;
  logic              w_clear;
  logic              w_wr_en;
  logic [IDXW-1:0]   w_wr_idx;
  logic              w_commit;

  // Handshake and bank controls are pure decodes of the registered state.
  always_comb begin
    cfg_ready = (r_state != ST_PEND);
    busy      = (r_state == ST_LOAD) || (r_state == ST_PEND);
    w_beat    = cfg_valid && cfg_ready;
`ifdef FIR_COEFF_CLEAR_EN
    w_clear   = (r_state == ST_IDLE) && cfg_clear;
`else
    w_clear   = 1'b0;
`endif
    // A clear in IDLE swallows any beat offered in the same cycle.
    w_wr_en   = w_beat && !w_clear &&
                ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    w_wr_idx  = (r_state == ST_IDLE) ? '0 : r_idx;
    w_commit  = (r_state == ST_PEND) && sample_strobe;
  end

  // Load sequencer: state, tap index and the two registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_commit_done <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_commit_done <= 1'b0;
      r_load_err    <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_clear) begin
            r_state <= ST_PEND;
            r_idx   <= '0;
          end else if (w_beat) begin
            if (cfg_last) begin
              // Single-beat load is always short.
              r_load_err <= 1'b1;
              r_idx      <= '0;
            end else begin
              r_state <= ST_LOAD;
              r_idx   <= IDXW'(1);
            end
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            if (r_idx == LAST_IDX) begin
              r_idx <= '0;
              if (cfg_last) begin
                r_state <= ST_PEND;
              end else begin
                r_load_err <= 1'b1;
                r_state    <= ST_DRAIN;
              end
            end else if (cfg_last) begin
              r_load_err <= 1'b1;
              r_state    <= ST_IDLE;
              r_idx      <= '0;
            end else begin
              r_idx <= r_idx + IDXW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_beat && cfg_last) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end
        end
        ST_PEND: begin
          if (sample_strobe) begin
            r_commit_done <= 1'b1;
            r_state       <= ST_IDLE;
            r_idx         <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign commit_done = r_commit_done;
  assign load_err    = r_load_err;

  fir_coeff_bank #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .IDXW  (IDXW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (cfg_data),
`ifdef FIR_COEFF_CLEAR_EN
    .i_clear   (w_clear),
`endif
    .i_commit  (w_commit),
    .o_active  (coeff_out)
  );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader (TAPS=4, WIDTH=16). A transaction-level model
// (queue of received beats, pending bank, drain flag) predicts every output
// each cycle; directed scenarios add literal expectations.
// Build with FIR_COEFF_CLEAR_EN defined to also cover cfg_clear.
module tb_fir_coeff_loader;

  localparam int W = 16;
  localparam int T = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [W-1:0]     cfg_data = '0;
  logic             cfg_last = 1'b0;
  logic             cfg_ready;
  logic             cfg_clear = 1'b0;
  logic             sample_strobe = 1'b0;
  logic [T*W-1:0]   coeff_out;
  logic             busy;
  logic             commit_done;
  logic             load_err;

  int n_checks = 0;
  int n_errors = 0;

  fir_coeff_loader #(.WIDTH(W), .TAPS(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_data      (cfg_data),
    .cfg_last      (cfg_last),
    .cfg_ready     (cfg_ready),
`ifdef FIR_COEFF_CLEAR_EN
    .cfg_clear     (cfg_clear),
`endif
    .sample_strobe (sample_strobe),
    .coeff_out     (coeff_out),
    .busy          (busy),
    .commit_done   (commit_done),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_active [T];
  logic [W-1:0] m_pend   [T];
  logic [W-1:0] m_q      [$];
  bit           m_pending;
  bit           m_draining;
  bit           m_commit;
  bit           m_err;

  function automatic logic [T*W-1:0] m_flat();
    return {m_active[3], m_active[2], m_active[1], m_active[0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < T; k++) begin
        m_active[k] = '0;
        m_pend[k]   = '0;
      end
      m_q.delete();
      m_pending  = 0;
      m_draining = 0;
      m_commit   = 0;
      m_err      = 0;
    end else begin
      m_commit = 0;
      m_err    = 0;
      if (m_pending) begin
        if (sample_strobe) begin
          for (int k = 0; k < T; k++) m_active[k] = m_pend[k];
          m_pending = 0;
          m_commit  = 1;
        end
`ifdef FIR_COEFF_CLEAR_EN
      end else if (cfg_clear && !m_draining && m_q.size() == 0) begin
        for (int k = 0; k < T; k++) m_pend[k] = '0;
        m_pending = 1;
`endif
      end else if (cfg_valid) begin
        if (m_draining) begin
          if (cfg_last) m_draining = 0;
        end else begin
          m_q.push_back(cfg_data);
          if (cfg_last) begin
            if (m_q.size() == T) begin
              for (int k = 0; k < T; k++) m_pend[k] = m_q[k];
              m_pending = 1;
            end else begin
              m_err = 1;
            end
            m_q.delete();
          end else if (m_q.size() == T) begin
            m_err      = 1;
            m_draining = 1;
            m_q.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("coeff_out",   coeff_out,   m_flat());
    check("cfg_ready",   cfg_ready,   !m_pending);
    check("busy",        busy,        m_pending || (m_q.size() > 0));
    check("commit_done", commit_done, m_commit);
    check("load_err",    load_err,    m_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic last, input logic strobe);
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    sample_strobe = strobe;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    sample_strobe = 1'b0;
  endtask

  task automatic load4(input logic [W-1:0] base);
    for (int i = 0; i < T; i++) beat(base + W'(i), (i == T - 1), 1'b0);
  endtask

  task automatic strobe();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  initial begin
    // reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick();
    check("idle_coeff", coeff_out, 64'h0);
    check("idle_ready", cfg_ready, 1'b1);
    check("idle_busy",  busy,      1'b0);

    // legal load, strobe 5 cycles later
    load4(16'h0001);
    repeat (5) tick();
    check("pend_ready", cfg_ready, 1'b0);
    check("pend_busy",  busy,      1'b1);
    strobe();
    check("legal_coeff",  coeff_out,   64'h0004_0003_0002_0001);
    check("legal_commit", commit_done, 1'b1);
    tick();
    check("commit_once",  commit_done, 1'b0);

    // short load
    beat(16'h00AA, 1'b0, 1'b0);
    beat(16'h00BB, 1'b1, 1'b0);
    check("short_err",  load_err, 1'b1);
    check("short_busy", busy,     1'b0);
    tick();
    check("short_err_once", load_err, 1'b0);
    strobe();
    check("short_keep", coeff_out, 64'h0004_0003_0002_0001);

    // long load: error after beat 4, beats 5..6 drained
    for (int i = 0; i < 6; i++) begin
      beat(16'h0100 + W'(i), (i == 5), 1'b0);
      if (i == 3) check("long_err", load_err, 1'b1);
      if (i == 4) check("long_drain_busy", busy, 1'b0);
    end
    strobe();
    check("long_keep", coeff_out, 64'h0004_0003_0002_0001);
    load4(16'h000A);
    strobe();
    check("after_long", coeff_out, 64'h000D_000C_000B_000A);

    // last beat coincident with strobe
    for (int i = 0; i < T; i++) beat(16'h0011 + W'(i), (i == T - 1), (i == T - 1));
    check("coinc_nocommit", coeff_out, 64'h000D_000C_000B_000A);
    check("coinc_busy",     busy,      1'b1);
    check("coinc_nodone",   commit_done, 1'b0);
    tick();
    strobe();
    check("coinc_commit", coeff_out, 64'h0014_0013_0012_0011);

    // reset during PEND
    load4(16'h0020);
    #2 rst_n = 1'b0;
    #1;
    check("rst_coeff", coeff_out, 64'h0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_busy",  busy,      1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

`ifdef FIR_COEFF_CLEAR_EN
    load4(16'h0030);
    strobe();
    check("pre_clear", coeff_out, 64'h0033_0032_0031_0030);
    cfg_clear = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 16'h7777;
    tick();
    cfg_clear = 1'b0;
    cfg_valid = 1'b0;
    check("clear_busy", busy, 1'b1);
    strobe();
    check("clear_coeff",  coeff_out,   64'h0);
    check("clear_commit", commit_done, 1'b1);
    tick();
`endif

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      cfg_valid     = ($urandom_range(0, 2) != 0);
      cfg_data      = W'($urandom);
      cfg_last      = ($urandom_range(0, 3) == 0);
      sample_strobe = ($urandom_range(0, 4) == 0);
`ifdef FIR_COEFF_CLEAR_EN
      cfg_clear     = ($urandom_range(0, 40) == 0);
`endif
      tick();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_clear = 1'b0;
    sample_strobe = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Configuration controller for the transposed FIR chain of `fir_block` instances. It accepts a serial stream of coefficients over a valid/ready handshake and assembles them into a shadow bank. At the next sample boundary it commits the shadow bank atomically to the active bank that drives every tap's `coeff` input, so the filter never runs on a mix of old and new coefficients.

## Interface
Parameters:
- `WIDTH`, 16, coefficient width; matches the FIR block `WIDTH`.
- `TAPS`, 8, number of taps (≥2); sets the bank depth.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: coefficient beat valid.
- `cfg_data` in WIDTH: coefficient value; beat k goes to tap k.
- `cfg_last` in 1: marks the final beat of a load.
- `cfg_ready` out 1: loader accepts a beat this cycle.
- `sample_strobe` in 1: one-cycle pulse when the chain's delay registers advance; the commit point.
- `coeff_out` out TAPS*WIDTH: active bank, flat; tap k occupies bits `[k*WIDTH +: WIDTH]`.
- `busy` out 1: high in LOAD or PEND.
- `commit_done` out 1: one-cycle pulse after the active bank updates.
- `load_err` out 1: one-cycle pulse when a load is aborted.

## Operation
- A beat transfers when `cfg_valid && cfg_ready`.
- FSM states and transitions:
  - IDLE: `cfg_ready`=1. An accepted beat writes shadow[0], sets idx to 1 and moves to LOAD.
    - If that beat also has `cfg_last`, it is an error; see below.
  - LOAD: `cfg_ready`=1. An accepted beat writes shadow[idx] and increments idx.
    - Beat at idx = TAPS-1 with `cfg_last`=1: go to PEND.
    - `cfg_last`=1 at idx < TAPS-1 (short load): pulse `load_err`, return to IDLE, shadow contents ignored.
    - Beat at idx = TAPS-1 with `cfg_last`=0 (long load): pulse `load_err`, go to DRAIN.
  - DRAIN: `cfg_ready`=1. Accept and discard beats until an accepted beat has `cfg_last`, then go to IDLE.
  - PEND: `cfg_ready`=0. Wait for `sample_strobe`, then copy shadow to active and go to IDLE.
- Whenever `load_err` pulses, the active bank is left unchanged.
- `busy` = (state == LOAD || state == PEND). DRAIN does not assert `busy`.
- The index counter is $clog2(TAPS) bits, cleared on every entry to IDLE. It never wraps inside a legal load.
- No arithmetic is performed. Coefficients are stored bit-exact, and signedness is left to the multiplier.

## Timing
- Reset (async assert, sync release): state=IDLE, idx=0, shadow=0, active=0 (so `coeff_out`=0), `commit_done`=0, `load_err`=0.
- `cfg_ready` and `busy` are combinational decodes of registered state. Every other output is registered.
- A shadow write lands on the edge where the beat is accepted.
- Commit latency:
  - `sample_strobe` high in PEND at edge N: `coeff_out` shows the new bank after edge N.
  - `commit_done` is high during cycle N+1, for exactly one cycle.
- `sample_strobe` in any state other than PEND has no effect.
- The final beat (`cfg_last`) and `sample_strobe` in the same cycle: the beat moves the FSM to PEND, but the strobe is not used. The commit waits for the next strobe.
- Reset mid-load or in PEND: the load is lost, and both banks return to 0.
- `load_err` is asserted in the cycle after the offending beat is accepted.

## Configuration
- Macro `FIR_COEFF_CLEAR_EN`.
- Defined:
  - Adds input `cfg_clear` (1 bit).
  - `cfg_clear`=1 in IDLE zeroes the whole shadow bank in one cycle and goes straight to PEND. The next `sample_strobe` commits all-zero coefficients, which mutes the filter.
  - `cfg_clear` outside IDLE is ignored.
  - `cfg_clear` takes priority over an accepted `cfg_valid` beat in the same IDLE cycle; that beat is consumed and dropped.
- Undefined: the port is absent and an all-zero bank is loadable only as TAPS beats of zero.

## Structure
- Package `fir_pkg`:
  - state enum (IDLE, LOAD, DRAIN, PEND);
  - default `WIDTH`/`TAPS` constants;
  - a function for the flat-bus slice offset.
- Sub-module `fir_coeff_bank` holds the shadow and active register arrays:
  - write-enable plus index for shadow writes;
  - a commit strobe for the shadow-to-active copy;
  - a clear input used only under `FIR_COEFF_CLEAR_EN`.
- The top level holds the FSM, index counter and pulse outputs.

## Test plan
All scenarios use TAPS=4, WIDTH=16.
- Reset, then idle for 10 cycles: `coeff_out`=0, `cfg_ready`=1, `busy`=0, no pulses.
- Legal load 0x0001, 0x0002, 0x0003, 0x0004 (last on 4th), then `sample_strobe` 5 cycles later:
  - `cfg_ready`=0 during the wait;
  - `coeff_out`=0x0004_0003_0002_0001 one cycle after the strobe, with `commit_done` in that cycle.
- Short load of 2 beats with `cfg_last` on the 2nd: `load_err` pulses once, state returns to IDLE, `coeff_out` keeps its previous value through a later strobe.
- Long load of 6 beats with last on the 6th: `load_err` after beat 4, beats 5–6 absorbed, active bank unchanged, next legal load commits correctly.
- The last beat coincident with `sample_strobe`: no commit on that edge; commit on the following strobe.
- Reset during PEND: outputs return to reset values. With `FIR_COEFF_CLEAR_EN`, `cfg_clear`, then a strobe: `coeff_out`=0 and `commit_done` pulses once.
